div_iter: RTL and testbench
===========================

# div_iter

Iterative radix-2 restoring divider for the execute stage of the 5-stage MIPS pipeline. It executes DIV and DIVU, producing the quotient for LO and the remainder for HI. While a division is in flight it drives `div_stall` into the hazard unit, which stalls F/D/E. Exceptions flushing from M cancel an in-flight division.

## Interface
Parameters:
- `WIDTH`, 32: operand width; quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_en`  in  1  E-stage instruction is DIV/DIVU; level, held by the E stall.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opa`  in  WIDTH  dividend (rs value after E-stage forwarding).
- `opb`  in  WIDTH  divisor (rt value after E-stage forwarding).
- `cancel`  in  1  exception flush from M (`flush_exceptionM`).
- `hold`  in  1  E stage held by a stall source other than this block.
- `div_stall`  out  1  to the hazard unit; E must not advance.
- `ready`  out  1  `result` valid this cycle.
- `result`  out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - `div_en & ~cancel`: latch operand magnitudes and the two sign flags, clear the counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY
  - Each cycle performs one restoring step:
    - shift {rem, quo} left by 1;
    - trial = rem − |divisor| at WIDTH+1 bits;
    - if trial is non-negative, rem = trial and quo LSB = 1.
  - After the WIDTH-th step, go to DONE.
- DONE
  - Drive the sign-corrected result with `ready`=1.
  - Go to IDLE when `~hold`. Stay in DONE, holding `result`, while `hold`=1.
  - A DONE→IDLE transition never restarts on the same instruction, because E advances on that edge.
- Sign correction (signed only):
  - quotient is negated if the dividend and divisor signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero: no trap.
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed: the same magnitude rule, then sign correction.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `cancel` in any state: next state IDLE; `ready` is not asserted for the cancelled operation. `cancel` together with `div_en` in IDLE does not start a division.
- Operands are sampled only on the IDLE→BUSY edge. Later changes on `opa`/`opb` are ignored.

## Timing
- `div_stall` = (IDLE & `div_en` & ~`cancel`) | BUSY. It is combinational from state and inputs, so it asserts in the first cycle the instruction sits in E.
- A division occupies E for WIDTH+2 cycles:
  - 1 IDLE-start cycle;
  - WIDTH BUSY cycles;
  - 1 DONE cycle, in which `div_stall`=0.
- `ready` = DONE; `result` is registered.
- Reset values:
  - state IDLE; counter 0;
  - `div_stall`=0, `ready`=0, `result`=0.
- Reset mid-operation aborts with the same effect as `cancel`.
- No output depends combinationally on `opa`/`opb`.

## Structure
- Shared package `div_pkg`:
  - state enum `div_state_t` {IDLE, BUSY, DONE};
  - `DIV_WIDTH`=32;
  - counter width constant $clog2(DIV_WIDTH)+1.
- One natural sub-module, `div_step`: a combinational single restoring step, with (rem, quo, divisor) in and (rem', quo') out. It is instantiated once and iterated by the FSM.
- Magnitude extraction and final negation live in the top module.

## Test plan
- **DIVU 100 / 7:** `div_en`=1, `signed_div`=0, `opa`=100, `opb`=7 → `div_stall` high for 33 cycles, then `ready`=1 with `result`={32'd2, 32'd14}.
- **DIV −7 / 2:** `opa`=0xFFFFFFF9, `opb`=2, `signed_div`=1 → `result`={0xFFFFFFFF, 0xFFFFFFFD}, i.e. remainder −1, quotient −3.
- **Overflow and divide by zero:**
  - DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - DIVU 5 / 0 → {5, 0xFFFFFFFF}.
- **Cancel mid-flight:** assert `cancel` in BUSY cycle 10 → `div_stall`=0 the next cycle, `ready` never asserts. A new `div_en` two cycles later completes correctly with fresh operands.
- **Hold in DONE:** hold `hold`=1 for 3 cycles during DONE → `ready` and `result` stable for all 3 cycles, and no restart. Then `hold`=0 → IDLE.
- **Async reset:** assert `rst` asynchronously mid-BUSY → all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step on unsigned magnitudes: shift {rem, quo} left,
// then subtract the divisor back out of rem if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor holds between steps, so WIDTH+1 bits cover both signs of trial.
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            remOut = trial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU; stalls the pipeline while busy.
//   state | meaning
//   IDLE  | waiting for a divide in E; start cycle asserts div_stall
//   BUSY  | one restoring step per cycle, WIDTH cycles
//   DONE  | result valid (ready), held while another source holds E
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_en,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               cancel,
    input  logic               hold,
    output logic               div_stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [DIV_CNT_W-1:0] LastCnt = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state, stateNext;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     remReg, quoReg, divisorReg;
    logic [WIDTH-1:0]     remNext, quoNext;
    logic [WIDTH-1:0]     opaMag, opbMag;
    logic [WIDTH-1:0]     remFix, quoFix;
    logic                 negQuo, negRem;
    logic                 start;

    assign start  = div_en & ~cancel;
    assign opaMag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    assign opbMag = (signed_div && opb[WIDTH-1]) ? -opb : opb;
    assign remFix = negRem ? -remNext : remNext;
    assign quoFix = negQuo ? -quoNext : quoNext;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = BUSY;
            BUSY: begin
                if (cancel)              stateNext = IDLE;
                else if (cnt == LastCnt) stateNext = DONE;
            end
            DONE: if (cancel || !hold) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        div_stall = ((state == IDLE) && start) || (state == BUSY);
        ready     = (state == DONE);
    end

    // Operands are captured only on the start cycle; the result register is
    // written once, on the final step, so it stays put through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt        <= '0;
                    remReg     <= '0;
                    quoReg     <= opaMag;
                    divisorReg <= opbMag;
                    negQuo     <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    negRem     <= signed_div & opa[WIDTH-1];
                end
                BUSY: begin
                    cnt    <= cnt + 1'b1;
                    remReg <= remNext;
                    quoReg <= quoNext;
                    if (cnt == LastCnt && !cancel) result <= {remFix, quoFix};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases, cancel, hold, async reset
// and randomized operands against an arithmetic reference.
module tb_div_iter;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           div_en = 1'b0;
    logic           signed_div = 1'b0;
    logic           cancel = 1'b0;
    logic           hold = 1'b0;
    logic [W-1:0]   opa = '0;
    logic [W-1:0]   opb = '0;
    logic           div_stall;
    logic           ready;
    logic [2*W-1:0] result;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_en     (div_en),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .cancel     (cancel),
        .hold       (hold),
        .div_stall  (div_stall),
        .ready      (ready),
        .result     (result)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Plain arithmetic on magnitudes, then sign rules; x/0 gives all ones, rem = x.
    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = (sgn && a[31]) ? 32'(0 - a) : a;
        mb = (sgn && b[31]) ? 32'(0 - b) : b;
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] != b[31])) q = 32'(0 - q);
        if (sgn && a[31])            r = 32'(0 - r);
        return {r, q};
    endfunction

    // Called at a negedge with div_en low; leaves the DUT back in IDLE.
    task automatic runOp(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int holdCycles);
        int n;
        signed_div = sgn;
        opa        = a;
        opb        = b;
        div_en     = 1'b1;
        #1;
        checkVal("stallStart", 64'(div_stall), 64'd1);
        n = 0;
        while (div_stall && n < 40) begin
            n++;
            @(negedge clk);
            opa = $urandom;
            opb = $urandom;
        end
        checkVal("stallLen", 64'(n), 64'd33);
        checkVal("readyDone", 64'(ready), 64'd1);
        checkVal("result", 64'(result), exp);
        if (holdCycles > 0) begin
            hold = 1'b1;
            for (int k = 0; k < holdCycles; k++) begin
                @(negedge clk);
                checkVal("holdReady", 64'(ready), 64'd1);
                checkVal("holdResult", 64'(result), exp);
                checkVal("holdNoStall", 64'(div_stall), 64'd0);
            end
        end
        hold   = 1'b0;
        div_en = 1'b0;
        @(negedge clk);
        checkVal("readyDrop", 64'(ready), 64'd0);
        checkVal("idleStall", 64'(div_stall), 64'd0);
    endtask

    initial begin
        logic        readySeen;
        bit          sgn;
        logic [31:0] a, b;

        #2;
        checkVal("rstStall", 64'(div_stall), 64'd0);
        checkVal("rstReady", 64'(ready), 64'd0);
        checkVal("rstResult", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 3);
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        runOp(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);
        runOp(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'd1}, 0);

        // Cancel in the tenth BUSY cycle, then a fresh divide.
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        div_en     = 1'b1;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        div_en = 1'b0;
        @(negedge clk);
        cancel = 1'b0;
        checkVal("cancelStall", 64'(div_stall), 64'd0);
        readySeen = ready;
        repeat (2) begin
            @(negedge clk);
            readySeen = readySeen | ready;
        end
        checkVal("cancelNoReady", 64'(readySeen), 64'd0);
        runOp(1'b0, 32'd1234567, 32'd89, {32'd1234567 % 32'd89, 32'd1234567 / 32'd89}, 0);

        // Cancel arriving together with div_en must not start.
        div_en = 1'b1;
        cancel = 1'b1;
        #1;
        checkVal("cancelStartStall", 64'(div_stall), 64'd0);
        @(negedge clk);
        div_en = 1'b0;
        cancel = 1'b0;
        #1;
        checkVal("cancelStartIdle", 64'(div_stall), 64'd0);
        @(negedge clk);

        // Asynchronous reset between clock edges while BUSY.
        signed_div = 1'b0;
        opa        = 32'd77777;
        opb        = 32'd5;
        div_en     = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst    = 1'b1;
        div_en = 1'b0;
        #1;
        checkVal("asyncStall", 64'(div_stall), 64'd0);
        checkVal("asyncReady", 64'(ready), 64'd0);
        checkVal("asyncResult", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        runOp(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 0);

        for (int i = 0; i < 16; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                default: b = $urandom;
            endcase
            runOp(sgn, a, b, refDiv(sgn, a, b), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
